// File: rtl/elastic_buffer_pkg.sv
// Shared constants and helpers for the elastic buffer.
// Mode encodings and the occupancy counter width.
package elastic_buffer_pkg;

  localparam int PKT_MODE_CUT_THROUGH = 0;
  localparam int PKT_MODE_STORE_FWD   = 1;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_buffer_ctrl.sv
// Pointer, occupancy and handshake control for the elastic buffer.
// All handshake outputs derive from registers only.
module elastic_buffer_ctrl
  import elastic_buffer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PACKET_MODE = PKT_MODE_CUT_THROUGH,
  parameter int CNT_W       = cnt_w(DEPTH),
  parameter int PTR_W       = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic             i_ready,
  input  logic             i_out_last,
  output logic             o_ready,
  output logic             o_valid,
  output logic             o_push,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PONE_C = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic             rel_q, rel_d;

  logic full, has_pkt, push, pop;
  logic pkt_push, pkt_pop;

  always_comb begin
    full    = (count_q == FULL_C);
    has_pkt = (pkt_count_q != '0);
    o_ready = !full;
    o_valid = (count_q != '0);
    if (PACKET_MODE == PKT_MODE_STORE_FWD) begin
      // Full-buffer term frees packets longer than DEPTH.
      o_valid = o_valid & (has_pkt | full | rel_q);
    end
  end

  always_comb begin
    push     = i_valid & o_ready;
    pop      = o_valid & i_ready;
    pkt_push = push & i_last;
    pkt_pop  = pop & i_out_last;

    wr_ptr_d = push ? wr_ptr_q + PONE_C : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PONE_C : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    pkt_count_d = pkt_count_q;
    unique case ({pkt_push, pkt_pop})
      2'b10:   pkt_count_d = pkt_count_q + ONE_C;
      2'b01:   pkt_count_d = pkt_count_q - ONE_C;
      default: pkt_count_d = pkt_count_q;
    endcase

    rel_d = rel_q;
    if (pkt_pop) begin
      rel_d = 1'b0;
    end else if (pop & full & !has_pkt) begin
      rel_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      rel_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      rel_q       <= rel_d;
    end
  end

  assign o_push   = push;
  assign o_wr_ptr = wr_ptr_q;
  assign o_rd_ptr = rd_ptr_q;
  assign o_count  = count_q;

endmodule

// File: rtl/elastic_buffer_core.sv
// DEPTH-entry elastic buffer with LAST flag, occupancy and
// optional store-and-forward packet mode.
module elastic_buffer_core
  import elastic_buffer_pkg::*;
#(
  parameter int NB_DATA           = 32,
  parameter int DEPTH             = 4,
  parameter int PACKET_MODE       = PKT_MODE_CUT_THROUGH,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [NB_DATA-1:0]        i_data,
  input  logic                      i_last,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [NB_DATA-1:0]        o_data,
  output logic                      o_last,
  input  logic                      i_ready,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_almost_full
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(ALMOST_FULL_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("elastic_buffer_core: DEPTH must be a power of two >= 2");
  end
  if ((ALMOST_FULL_LEVEL < 1) || (ALMOST_FULL_LEVEL > DEPTH)) begin : g_bad_af
    $error("elastic_buffer_core: ALMOST_FULL_LEVEL out of 1..DEPTH");
  end
  if ((PACKET_MODE != PKT_MODE_CUT_THROUGH) &&
      (PACKET_MODE != PKT_MODE_STORE_FWD)) begin : g_bad_mode
    $error("elastic_buffer_core: PACKET_MODE must be 0 or 1");
  end

  logic [NB_DATA:0]   mem_q [DEPTH];
  logic [NB_DATA:0]   rd_entry;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;

  elastic_buffer_ctrl #(
    .DEPTH       (DEPTH),
    .PACKET_MODE (PACKET_MODE),
    .CNT_W       (CNT_W),
    .PTR_W       (PTR_W)
  ) u_ctrl (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .i_ready    (i_ready),
    .i_out_last (o_last),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_push     (push),
    .o_wr_ptr   (wr_ptr),
    .o_rd_ptr   (rd_ptr),
    .o_count    (count)
  );

  // Payload storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr] <= {i_last, i_data};
    end
  end

  always_comb begin
    rd_entry      = mem_q[rd_ptr];
    o_data        = rd_entry[NB_DATA-1:0];
    o_last        = rd_entry[NB_DATA];
    o_count       = count;
    o_almost_full = (count >= AF_C);
  end

endmodule

// File: doc/elastic_buffer_core.md
Name: elastic_buffer_core

Overview:
Parametrised successor to the single-entry skid buffer: a DEPTH-entry elastic buffer carrying one flat data vector plus a LAST flag. Both sides use valid/ready handshakes with fully registered control, so there is no combinational path from i_ready to o_ready.
Adds occupancy reporting, an almost-full flag and an optional packet (store-and-forward) mode. AXIS wrappers concatenate TUSER/TDEST/TID/TKEEP/TSTRB/TDATA into i_data and carry TLAST on i_last.

Parameters:
NB_DATA, 32, width of i_data/o_data
DEPTH, 4, number of entries; power of two, >= 2
PACKET_MODE, 0, 0 = cut-through; 1 = output held until a complete packet (LAST beat) is stored
ALMOST_FULL_LEVEL, DEPTH-1, o_almost_full asserts when occupancy >= this value; legal range 1..DEPTH

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  upstream beat valid
i_data  in  NB_DATA  upstream beat payload
i_last  in  1  upstream beat is last of packet
o_ready  out  1  buffer can accept a beat this cycle
o_valid  out  1  downstream beat valid
o_data  out  NB_DATA  downstream payload
o_last  out  1  downstream LAST
i_ready  in  1  downstream accepts beat
o_count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
o_almost_full  out  1  o_count >= ALMOST_FULL_LEVEL

Behaviour:
- Push = i_valid & o_ready. Pop = o_valid & i_ready. Both may happen in one cycle.
- Storage: circular array of DEPTH x (NB_DATA+1) entries, with wr_ptr/rd_ptr of $clog2(DEPTH) bits. Pointers wrap naturally because DEPTH is a power of two.
- count register: +1 on push only, -1 on pop only, unchanged on both or neither.
- o_ready = (count != DEPTH). It depends on registers only. A push while full is never accepted, even if a pop occurs in the same cycle.
- Cut-through latency: a beat pushed into an empty buffer at cycle N gives o_valid=1 at N+1. Sustained throughput is 1 beat/cycle while not full.
- o_data/o_last = array[rd_ptr]. They must hold stable while o_valid & !i_ready.
- PACKET_MODE=0: o_valid = (count != 0).
- PACKET_MODE=1:
  - pkt_count (same width as count): +1 on a push with i_last, -1 on a pop with o_last, unchanged if both.
  - o_valid = (count != 0) & ((pkt_count != 0) | (count == DEPTH)).
  - The full-buffer term is a deadlock escape for packets longer than DEPTH. Once it releases a beat, output continues while count != 0. A release flag is set on the release and cleared on a pop with o_last.
- o_valid never deasserts without a pop, except on reset.
- Reset (any cycle, including mid-packet or while full):
  - pointers, count and pkt_count go to 0; release flag is cleared.
  - o_valid=0, o_count=0, o_almost_full=0, o_ready=1 from the cycle after i_rst is sampled high.
  - o_data/o_last are don't-care while o_valid=0.
  - Stored data is discarded. Array contents are not reset.
- o_almost_full is registered-equivalent: a compare on the count register.
- Elaboration checks raise $error when:
  - DEPTH is not a power of two, or DEPTH < 2;
  - ALMOST_FULL_LEVEL is outside 1..DEPTH;
  - PACKET_MODE is not 0 or 1.

Decomposition:
- Shared package elastic_buffer_pkg: the localparam function for the count width. It also holds the mode constants PKT_MODE_CUT_THROUGH=0 and PKT_MODE_STORE_FWD=1.
- One sub-module, elastic_buffer_ctrl: pointers, count, pkt_count, release flag, o_ready/o_valid generation.
- The storage array stays in the top level.
- An AXIS wrapper, axis_elastic_buffer, packs/unpacks interface fields as a separate file. It is outside this block's scope.

Test Plan:
All scenarios use NB_DATA=8, DEPTH=4, ALMOST_FULL_LEVEL=3.
1. Cut-through streaming: i_valid=1, data 0x01..0x10, i_ready=1 throughout -> o_valid first high 1 cycle after the first push. 16 beats out in order at 1 beat/cycle, o_count stays <= 1.
2. Fill/backpressure: i_ready=0, push 0xA0..0xA5 -> 4 accepted. o_ready=0 after the 4th, o_count=4, o_almost_full=1 from count 3. Then i_ready=1 -> 0xA0..0xA3 drain, and o_ready returns 1 the cycle after the first pop.
3. Full with simultaneous push attempt and pop: count=4, i_valid=1, i_ready=1 -> only the pop occurs, count=3. The next cycle the push is accepted, count stays 3 under a steady push+pop.
4. Packet mode: PACKET_MODE=1, push 3 beats 0x11,0x22,0x33 (last on 0x33) with i_ready=1 -> o_valid stays 0 until the cycle after 0x33 is stored. The 3 beats then emerge consecutively, o_last on 0x33.
5. Packet-mode escape: PACKET_MODE=1, a 6-beat packet -> at count=4 with pkt_count=0, output releases. All 6 beats are delivered in order with o_last on the 6th, and no deadlock.
6. Reset mid-operation: count=3, pkt_count=1, assert i_rst 1 cycle -> next cycle o_valid=0, o_count=0, o_ready=1. A fresh push 0x5A appears on o_data 1 cycle later.
